// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: external data-memory port of mem_access_unit.
//   mem_req_o   : access request, held high until acknowledged
//   mem_we_o    : 1 = store, 0 = load
//   mem_addr_o  : byte address, stable while mem_req_o is high
//   mem_wdata_o : store data, stable while mem_req_o is high
//   mem_ack_i   : single-cycle completion pulse from memory
//   mem_rdata_i : load data, valid while mem_ack_i is high
// Modports: master (access unit side), slave (memory side).
interface mem_access_unit_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle data-memory stage between EXMEM and MEMWB.
// LW/SW from EXMEM become one req/ack transaction on the memory port while
// the pipeline is stalled; other instructions pass through with no latency.
// Ports:
//   clk_i, rst_i (async, active-low)
//   control_i/ALUResult_i/RS2data_i/RDaddr_i : from EXMEM
//   control_o/ALUResult_o/memData_o/RDaddr_o : to MEMWB
//   stall_o : freezes PC, IFID, IDEX, EXMEM
//   mem     : memory port (mem_access_unit_if.master)
//   err_o   : sticky timeout flag
// Build option: define MEM_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES
// cycles without ack (load data DEADBEEF, err_o set until reset).
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [3:0]                control_i,
    input  logic [31:0]               ALUResult_i,
    input  logic [31:0]               RS2data_i,
    input  logic [4:0]                RDaddr_i,
    output logic [3:0]                control_o,
    output logic [31:0]               ALUResult_o,
    output logic [31:0]               memData_o,
    output logic [4:0]                RDaddr_o,
    output logic                      stall_o,
    mem_access_unit_if.master         mem,
    output logic                      err_o
);
    // Control encodings shared with the rest of the pipeline.
    localparam logic [3:0] Ctrl_NOP = 4'h0;
    localparam logic [3:0] Ctrl_LW  = 4'h8;
    localparam logic [3:0] Ctrl_SW  = 4'h9;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_access_unit: TIMEOUT_CYCLES must be 1..255");
    end

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        is_mem_op;
    logic        timeout_hit;

    assign is_mem_op = (control_i == Ctrl_LW) || (control_i == Ctrl_SW);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] to_cnt_q;
    logic       err_q;

    // Abort on the edge where the no-ack count would reach TIMEOUT_CYCLES,
    // so REQ lasts exactly TIMEOUT_CYCLES cycles. An ack in that cycle wins.
    assign timeout_hit = (state_q == REQ) && !mem.mem_ack_i &&
                         (to_cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && state_d == REQ) begin
                to_cnt_q <= '0;
            end else if (state_q == REQ && !mem.mem_ack_i) begin
                to_cnt_q <= to_cnt_q + 8'd1;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && is_mem_op) begin
                addr_q  <= ALUResult_i;
                wdata_q <= RS2data_i;
                we_q    <= (control_i == Ctrl_SW);
            end
            if (state_q == REQ && mem.mem_ack_i) begin
                rdata_q <= we_q ? '0 : mem.mem_rdata_i;
            end else if (timeout_hit) begin
                rdata_q <= 32'hDEADBEEF;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (is_mem_op) begin
                    stall_o = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (mem.mem_ack_i || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // EXMEM advances on this edge, so the next IDLE cycle sees
                // the following instruction rather than this one again.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign control_o       = stall_o ? Ctrl_NOP : control_i;
    assign memData_o       = (state_q == DONE) ? rdata_q : '0;
    assign ALUResult_o     = ALUResult_i;
    assign RDaddr_o        = RDaddr_i;

    // Request follows the state directly so reset drops it asynchronously.
    assign mem.mem_req_o   = (state_q == REQ);
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    localparam logic [3:0] Ctrl_NOP = 4'h0;
    localparam logic [3:0] Ctrl_ADD = 4'h1;
    localparam logic [3:0] Ctrl_SUB = 4'h2;
    localparam logic [3:0] Ctrl_AND = 4'h3;
    localparam logic [3:0] Ctrl_OR  = 4'h4;
    localparam logic [3:0] Ctrl_XOR = 4'h5;
    localparam logic [3:0] Ctrl_LW  = 4'h8;
    localparam logic [3:0] Ctrl_SW  = 4'h9;
    localparam logic [3:0] Ctrl_BEQ = 4'hA;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned MAXN = 4;
`else
    localparam int unsigned MAXN = 8;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  control_i;
    logic [31:0] ALUResult_i;
    logic [31:0] RS2data_i;
    logic [4:0]  RDaddr_i;
    logic [3:0]  control_o;
    logic [31:0] ALUResult_o;
    logic [31:0] memData_o;
    logic [4:0]  RDaddr_o;
    logic        stall_o;
    logic        err_o;

    mem_access_unit_if mem ();

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .control_i   (control_i),
        .ALUResult_i (ALUResult_i),
        .RS2data_i   (RS2data_i),
        .RDaddr_i    (RDaddr_i),
        .control_o   (control_o),
        .ALUResult_o (ALUResult_o),
        .memData_o   (memData_o),
        .RDaddr_o    (RDaddr_o),
        .stall_o     (stall_o),
        .mem         (mem),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;
    int unsigned stall_seen  = 0;
    int unsigned nop_seen    = 0;
    int unsigned req_seen    = 0;
    logic        exp_err     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    // One non-memory instruction: single cycle, no stall, straight through.
    task automatic run_alu(input logic [3:0] op, input logic [31:0] alu, input logic [4:0] rd);
        control_i   = op;
        ALUResult_i = alu;
        RS2data_i   = $urandom;
        RDaddr_i    = rd;
        mem.mem_ack_i   = ($urandom_range(0, 3) == 0);
        mem.mem_rdata_i = $urandom;
        @(negedge clk_i);
        chk("alu_stall", 32'(stall_o), 32'(1'b0));
        chk("alu_ctrl", 32'(control_o), 32'(op));
        chk("alu_result", ALUResult_o, alu);
        chk("alu_rd", 32'(RDaddr_o), 32'(rd));
        chk("alu_memdata", memData_o, 32'h0);
        chk("alu_req", 32'(mem.mem_req_o), 32'(1'b0));
        chk("alu_err", 32'(err_o), 32'(exp_err));
        next_cycle();
    endtask

    // One LW/SW acked in REQ cycle n (n>=1): expected timeline is
    // n+1 stalled bubble cycles then one DONE cycle presenting the data.
    task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd, input int unsigned n, input logic [31:0] rdata);
        logic is_req;
        logic is_done;
        for (int unsigned c = 0; c <= n + 1; c++) begin
            is_req  = (c >= 1) && (c <= n);
            is_done = (c == n + 1);
            control_i   = op;
            ALUResult_i = addr;
            RS2data_i   = wdata;
            RDaddr_i    = rd;
            if (is_req) mem.mem_ack_i = (c == n);
            else        mem.mem_ack_i = ($urandom_range(0, 3) == 0);
            mem.mem_rdata_i = (is_req && c == n) ? rdata : $urandom;
            @(negedge clk_i);
            if (stall_o) stall_seen++;
            if (control_o == Ctrl_NOP) nop_seen++;
            if (mem.mem_req_o) req_seen++;
            chk("mem_stall", 32'(stall_o), 32'(!is_done));
            chk("mem_ctrl", 32'(control_o), 32'(is_done ? op : Ctrl_NOP));
            chk("mem_result", ALUResult_o, addr);
            chk("mem_rd", 32'(RDaddr_o), 32'(rd));
            chk("mem_req", 32'(mem.mem_req_o), 32'(is_req));
            chk("mem_memdata", memData_o, is_done ? ((op == Ctrl_LW) ? rdata : 32'h0) : 32'h0);
            if (is_req) begin
                chk("mem_we", 32'(mem.mem_we_o), 32'(op == Ctrl_SW));
                chk("mem_addr", mem.mem_addr_o, addr);
                chk("mem_wdata", mem.mem_wdata_o, wdata);
            end
            chk("mem_err", 32'(err_o), 32'(exp_err));
            next_cycle();
        end
    endtask

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [3:0]  exp_ctrl;
        logic        exp_stall;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int unsigned t0;
        logic [3:0] op;

        tbl[0] = '{Ctrl_ADD, 32'd5,          5'd1,  Ctrl_ADD, 1'b0};
        tbl[1] = '{Ctrl_SUB, 32'hFFFF_FFFF,  5'd31, Ctrl_SUB, 1'b0};
        tbl[2] = '{Ctrl_NOP, 32'h0,          5'd0,  Ctrl_NOP, 1'b0};
        tbl[3] = '{Ctrl_BEQ, 32'h8000_0000,  5'd7,  Ctrl_BEQ, 1'b0};
        tbl[4] = '{Ctrl_XOR, 32'h1234_5678,  5'd16, Ctrl_XOR, 1'b0};
        tbl[5] = '{Ctrl_OR,  32'hA5A5_A5A5,  5'd2,  Ctrl_OR,  1'b0};

        rst_i       = 1'b0;
        control_i   = Ctrl_NOP;
        ALUResult_i = '0;
        RS2data_i   = '0;
        RDaddr_i    = '0;
        mem.mem_ack_i   = 1'b0;
        mem.mem_rdata_i = '0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_req", 32'(mem.mem_req_o), 32'(1'b0));
        chk("rst_we", 32'(mem.mem_we_o), 32'(1'b0));
        chk("rst_addr", mem.mem_addr_o, 32'h0);
        chk("rst_wdata", mem.mem_wdata_o, 32'h0);
        chk("rst_memdata", memData_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'(1'b0));
        chk("rst_stall", 32'(stall_o), 32'(1'b0));
        next_cycle();
        rst_i = 1'b1;

        // Table of pass-through vectors
        for (int i = 0; i < 6; i++) begin
            control_i   = tbl[i].ctrl;
            ALUResult_i = tbl[i].alu;
            RDaddr_i    = tbl[i].rd;
            @(negedge clk_i);
            chk("tbl_stall", 32'(stall_o), 32'(tbl[i].exp_stall));
            chk("tbl_ctrl", 32'(control_o), 32'(tbl[i].exp_ctrl));
            chk("tbl_result", ALUResult_o, tbl[i].alu);
            chk("tbl_rd", 32'(RDaddr_o), 32'(tbl[i].rd));
            chk("tbl_req", 32'(mem.mem_req_o), 32'(1'b0));
            next_cycle();
        end

        // LW acked in first REQ cycle: 2 stall cycles, one request
        stall_seen = 0; req_seen = 0;
        run_mem(Ctrl_LW, 32'h40, 32'h0, 5'd3, 1, 32'h1234);
        chk("lw_stalls", stall_seen, 2);
        chk("lw_reqs", req_seen, 1);

        // SW acked after 4 REQ cycles: 5 stall cycles
        stall_seen = 0;
        run_mem(Ctrl_SW, 32'h80, 32'hCAFE, 5'd0, 4, 32'hFFFF_0000);
        chk("sw_stalls", stall_seen, 5);

        // Back-to-back loads: 6 cycles, 2 requests, 4 bubbles
        t0 = cyc; req_seen = 0; nop_seen = 0;
        run_mem(Ctrl_LW, 32'h100, 32'h0, 5'd4, 1, 32'h1111_1111);
        run_mem(Ctrl_LW, 32'h104, 32'h0, 5'd5, 1, 32'h2222_2222);
        chk("b2b_cycles", cyc - t0, 6);
        chk("b2b_reqs", req_seen, 2);
        chk("b2b_bubbles", nop_seen, 4);

        // Reset during REQ, then a late ack
        control_i = Ctrl_LW; ALUResult_i = 32'h200; mem.mem_ack_i = 1'b0;
        next_cycle();
        @(negedge clk_i);
        chk("midrst_req_before", 32'(mem.mem_req_o), 32'(1'b1));
        #1;
        rst_i = 1'b0;
        control_i = Ctrl_NOP;
        #1;
        chk("midrst_req_async", 32'(mem.mem_req_o), 32'(1'b0));
        chk("midrst_stall", 32'(stall_o), 32'(1'b0));
        next_cycle();
        rst_i = 1'b1;
        control_i = Ctrl_ADD; ALUResult_i = 32'h77;
        mem.mem_ack_i = 1'b1; mem.mem_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk_i);
        chk("late_ack_req", 32'(mem.mem_req_o), 32'(1'b0));
        chk("late_ack_stall", 32'(stall_o), 32'(1'b0));
        next_cycle();
        mem.mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("late_ack_memdata", memData_o, 32'h0);
        chk("late_ack_ctrl", 32'(control_o), 32'(Ctrl_ADD));
        next_cycle();

        // Randomized instruction stream against the timeline model
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 5))
                0: op = Ctrl_LW;
                1: op = Ctrl_SW;
                2: op = Ctrl_ADD;
                3: op = Ctrl_AND;
                4: op = Ctrl_NOP;
                default: op = Ctrl_SUB;
            endcase
            if (op == Ctrl_LW || op == Ctrl_SW)
                run_mem(op, $urandom, $urandom, 5'($urandom), $urandom_range(1, MAXN), $urandom);
            else
                run_alu(op, $urandom, 5'($urandom));
        end

`ifdef MEM_TIMEOUT_EN
        // Ack in the very cycle the timeout would fire: normal completion
        run_mem(Ctrl_LW, 32'h300, 32'h0, 5'd6, 4, 32'h5555_AAAA);

        // Never acked: 4 REQ cycles then DONE with DEADBEEF and sticky error
        control_i = Ctrl_LW; ALUResult_i = 32'h400; mem.mem_ack_i = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk_i);
            chk("to_req", 32'(mem.mem_req_o), 32'((c >= 1) && (c <= 4)));
            chk("to_stall", 32'(stall_o), 32'(c != 5));
            if (c == 5) begin
                chk("to_memdata", memData_o, 32'hDEADBEEF);
                chk("to_err", 32'(err_o), 32'(1'b1));
            end
            next_cycle();
        end
        exp_err = 1'b1;
        run_alu(Ctrl_ADD, 32'h9, 5'd9);
        run_mem(Ctrl_LW, 32'h500, 32'h0, 5'd8, 2, 32'h0BAD_F00D);
        rst_i = 1'b0;
        #1;
        chk("to_err_cleared", 32'(err_o), 32'(1'b0));
        exp_err = 1'b0;
        next_cycle();
        rst_i = 1'b1;
        run_alu(Ctrl_ADD, 32'h1, 5'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
